multi_port_stream_packer: RTL and testbench

Registered packing stage that sits directly upstream of the multi-port stream FIFO's enqueue side. It accepts one wide beat of `InWidth` sparsely-masked lanes and holds it in a single register. It then emits the valid lanes in ascending lane order as a contiguous prefix of `OutWidth` output lanes, which is the form the FIFO's `enq_vld`/`enq_rdy` ports require. A wide beat drains over one or more cycles as the FIFO accepts lanes.

---
 rtl/multi_port_stream_packer_if.sv | 26 ++
 rtl/multi_port_stream_packer.sv | 104 ++++++++++
 tb/tb_multi_port_stream_packer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multi_port_stream_packer_if.sv
// Wide-beat input bus and packed multi-lane output bus for the stream packer.
// master drives beats and downstream readiness; slave is the packer itself.
interface multi_port_stream_packer_if #(
  parameter int InWidth   = 4,
  parameter int OutWidth  = 2,
  parameter int DataWidth = 32
);
  logic                                flush_i;
  logic                                in_vld_i;
  logic [InWidth-1:0]                  in_mask_i;
  logic [InWidth-1:0][DataWidth-1:0]   in_payload_i;
  logic                                in_rdy_o;
  logic [OutWidth-1:0]                 out_vld_o;
  logic [OutWidth-1:0][DataWidth-1:0]  out_payload_o;
  logic [OutWidth-1:0]                 out_rdy_i;

  modport master (
    output flush_i, in_vld_i, in_mask_i, in_payload_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_payload_o
  );

  modport slave (
    input  flush_i, in_vld_i, in_mask_i, in_payload_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_payload_o
  );
endinterface

// File: rtl/multi_port_stream_packer.sv
// Holds one sparsely-masked wide beat and emits its valid lanes, lowest lane
// first, as a contiguous prefix of output lanes until the beat is drained.
module multi_port_stream_packer #(
  parameter int InWidth   = 4,
  parameter int OutWidth  = 2,
  parameter int DataWidth = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_port_stream_packer_if.slave bus
);

  localparam int CntW = $clog2(InWidth + 1);

  logic [InWidth-1:0]                 pend_q, pend_d;
  logic [InWidth-1:0][DataWidth-1:0]  hold_q, hold_d;
  logic [InWidth-1:0][CntW-1:0]       rank_s;
  logic [CntW-1:0]                    pcnt_s;
  logic [CntW-1:0]                    fire_n_s;
  logic [OutWidth-1:0]                vld_s;
  logic [OutWidth-1:0]                vld_gated_s;
  logic [OutWidth-1:0][DataWidth-1:0] pay_s;
  logic                               rdy_s;
  logic                               accept_s;

  function automatic logic [CntW-1:0] popcount(input logic [InWidth-1:0] m);
    logic [CntW-1:0] c;
    c = {CntW{1'b0}};
    for (int i = 0; i < InWidth; i++) begin
      c = c + CntW'(m[i]);
    end
    return c;
  endfunction

  assign pcnt_s = popcount(pend_q);

  // Rank every held lane among the pending ones and route rank k to output k.
  always_comb begin
    rank_s = '0;
    pay_s  = '0;
    vld_s  = '0;
    for (int i = 0; i < InWidth; i++) begin
      rank_s[i] = popcount(pend_q & ((InWidth'(1) << i) - InWidth'(1)));
      for (int k = 0; k < OutWidth; k++) begin
        pay_s[k] = (pend_q[i] && (rank_s[i] == CntW'(k))) ? hold_q[i] : pay_s[k];
      end
    end
    for (int k = 0; k < OutWidth; k++) begin
      vld_s[k] = (pcnt_s > CntW'(k));
    end
  end

  // Suppress output under reset/flush, then count the firing prefix.
  always_comb begin
    logic run;
    run      = 1'b1;
    fire_n_s = {CntW{1'b0}};
    if (rst || bus.flush_i) begin
      vld_gated_s = '0;
    end else begin
      vld_gated_s = vld_s;
    end
    for (int k = 0; k < OutWidth; k++) begin
      run      = run & vld_gated_s[k] & bus.out_rdy_i[k];
      fire_n_s = fire_n_s + CntW'(run);
    end
  end

  // An empty stage and one whose last lanes fire now both take a new beat.
  assign rdy_s    = !rst && !bus.flush_i && (fire_n_s == pcnt_s);
  assign accept_s = bus.in_vld_i && rdy_s;

  // Next held beat: flush empties, accept replaces, otherwise retire fired lanes.
  always_comb begin
    pend_d = '0;
    hold_d = hold_q;
    if (bus.flush_i) begin
      pend_d = '0;
    end else if (accept_s) begin
      pend_d = bus.in_mask_i;
      hold_d = bus.in_payload_i;
    end else begin
      for (int i = 0; i < InWidth; i++) begin
        pend_d[i] = pend_q[i] && (rank_s[i] >= fire_n_s);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

  assign bus.in_rdy_o      = rdy_s;
  assign bus.out_vld_o     = vld_gated_s;
  assign bus.out_payload_o = pay_s;

endmodule

// File: tb/tb_multi_port_stream_packer.sv
// Randomised and directed checks of the stream packer against a queue-based
// model of the lanes still owed downstream.
module tb_multi_port_stream_packer;

  localparam int IW = 4;
  localparam int OW = 2;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [DW-1:0] exp_q[$];

  multi_port_stream_packer_if #(.InWidth(IW), .OutWidth(OW), .DataWidth(DW)) bus ();

  multi_port_stream_packer #(.InWidth(IW), .OutWidth(OW), .DataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic f, input logic v, input logic [IW-1:0] m,
                      input logic [IW-1:0][DW-1:0] p, input logic [OW-1:0] ry);
    int            pend;
    int            n;
    logic [OW-1:0] e_vld;
    logic          e_rdy;
    rst              = r;
    bus.flush_i      = f;
    bus.in_vld_i     = v;
    bus.in_mask_i    = m;
    bus.in_payload_i = p;
    bus.out_rdy_i    = ry;
    #3;
    pend  = exp_q.size();
    e_vld = '0;
    n     = 0;
    if (!r && !f) begin
      for (int k = 0; k < OW; k++) e_vld[k] = (pend > k);
      for (int k = 0; k < OW; k++) begin
        if (k < pend && ry[k]) n++;
        else break;
      end
    end
    e_rdy = !r && !f && (n == pend);
    check("out_vld", 64'(bus.out_vld_o), 64'(e_vld));
    check("in_rdy", 64'(bus.in_rdy_o), 64'(e_rdy));
    for (int k = 0; k < OW; k++) begin
      if (e_vld[k]) check($sformatf("pay%0d", k), 64'(bus.out_payload_o[k]), 64'(exp_q[k]));
    end
    if (r || f) begin
      exp_q.delete();
    end else begin
      for (int k = 0; k < n; k++) void'(exp_q.pop_front());
      if (v && e_rdy) begin
        exp_q.delete();
        for (int i = 0; i < IW; i++) if (m[i]) exp_q.push_back(p[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0][DW-1:0] pay;
    logic [IW-1:0][DW-1:0] zero_pay;
    int                    rst_at;
    n_pass   = 0;
    n_total  = 0;
    zero_pay = '0;
    for (int i = 0; i < IW; i++) pay[i] = DW'(32'hA0A0_0000 + 32'(i));

    repeat (3) step(1'b1, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b00);
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);

    // Sparse beat 1011 drains A,B then D.
    step(1'b0, 1'b0, 1'b1, 4'b1011, pay, 2'b11);
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);

    // Back-to-back two-lane beats.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < IW; i++) pay[i] = DW'($urandom);
      step(1'b0, 1'b0, 1'b1, 4'b0011, pay, 2'b11);
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);

    // Non-prefix ready stalls, then single-lane drain.
    step(1'b0, 1'b0, 1'b1, 4'b0111, pay, 2'b11);
    repeat (2) step(1'b0, 1'b0, 1'b1, 4'b1111, zero_pay, 2'b10);
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b01);
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);

    // Zero-mask beat, then flush mid-drain with a beat offered.
    step(1'b0, 1'b0, 1'b1, 4'b0000, pay, 2'b11);
    step(1'b0, 1'b0, 1'b1, 4'b1111, pay, 2'b11);
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);
    step(1'b0, 1'b1, 1'b1, 4'b0001, pay, 2'b11);
    step(1'b0, 1'b0, 1'b0, 4'b0000, zero_pay, 2'b11);

    // Random traffic with one reset landing mid-run.
    rst_at = int'($urandom_range(500, 1500));
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < IW; i++) pay[i] = DW'($urandom);
      step((c == rst_at) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           IW'($urandom), pay, OW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
